// File: rtl/host_frame_loader.sv
// Host download frame parser: SYNC, ADDR_HI, ADDR_LO, LEN, DATA x N, CHK -> image buffer writes + start pulse.
// Optional ACK/NAK byte return to the host is enabled by defining HOST_FRAME_ACK_EN.
module host_frame_loader #(
    parameter int          ADDR_W         = 11,
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int          TIMEOUT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              new_rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [ADDR_W-1:0] frame_base,
    output logic [8:0]        frame_len,
    output logic              in_frame
`ifdef HOST_FRAME_ACK_EN
    ,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    input  logic              tx_busy
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_AHI, S_ALO, S_LEN, S_DATA, S_CHK} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [8:0]        len_q, len_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] fbase_q, fbase_d;
    logic [8:0]        flen_q, flen_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fbase_q   <= '0;
            flen_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fbase_q   <= fbase_d;
            flen_q    <= flen_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        tmo_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fbase_d   = fbase_q;
        flen_d    = flen_q;

        if (new_rx_data) begin
            // A strobe always wins over a timeout expiring on the same cycle.
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) state_d = S_AHI;
                end
                S_AHI: begin
                    addr_d  = {rx_data[ADDR_W-9:0], 8'h00};
                    sum_d   = rx_data;
                    state_d = S_ALO;
                end
                S_ALO: begin
                    addr_d[7:0] = rx_data;
                    sum_d       = sum_q + rx_data;
                    state_d     = S_LEN;
                end
                S_LEN: begin
                    cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    len_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    sum_d   = sum_q + rx_data;
                    base_d  = addr_q;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = rx_data;
                    addr_d    = addr_q + ADDR_W'(1);
                    sum_d     = sum_q + rx_data;
                    cnt_d     = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (8'(sum_q + rx_data) == 8'h00) begin
                        done_d  = 1'b1;
                        fbase_d = base_q;
                        flen_d  = len_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_base = fbase_q;
    assign frame_len  = flen_q;
    assign in_frame   = (state_q != S_IDLE);

`ifdef HOST_FRAME_ACK_EN
    logic       ack_pend_q, ack_pend_d;
    logic [7:0] ack_byte_q, ack_byte_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_pend_q <= 1'b0;
            ack_byte_q <= '0;
        end else begin
            ack_pend_q <= ack_pend_d;
            ack_byte_q <= ack_byte_d;
        end
    end

    // One-deep response slot; a fresh result replaces one still waiting for the UART.
    always_comb begin
        ack_pend_d = ack_pend_q;
        ack_byte_d = ack_byte_q;
        if (ack_pend_q && !tx_busy) ack_pend_d = 1'b0;
        if (done_q) begin
            ack_pend_d = 1'b1;
            ack_byte_d = 8'h06;
        end else if (err_q) begin
            ack_pend_d = 1'b1;
            ack_byte_d = 8'h15;
        end
    end

    assign tx_data     = ack_byte_q;
    assign new_tx_data = ack_pend_q & ~tx_busy;
`endif

endmodule

// File: tb/tb_host_frame_loader.sv
// Randomized bench for host_frame_loader with a frame-level reference model (checksum/addresses from plain arithmetic).
module tb_host_frame_loader;

    localparam int ADDR_W = 11;
    localparam int TMO    = 300;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              new_rx_data = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              frame_err;
    logic [ADDR_W-1:0] frame_base;
    logic [8:0]        frame_len;
    logic              in_frame;
`ifdef HOST_FRAME_ACK_EN
    logic [7:0]        tx_data;
    logic              new_tx_data;
    logic              tx_busy = 1'b1;
    logic [7:0]        ack_q[$];
`endif

    host_frame_loader #(
        .ADDR_W(ADDR_W), .SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_err(frame_err),
        .frame_base(frame_base), .frame_len(frame_len), .in_frame(in_frame)
`ifdef HOST_FRAME_ACK_EN
        , .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy)
`endif
    );

    always #5 clk = ~clk;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [ADDR_W-1:0] exp_base = '0;
    logic [8:0]        exp_len  = '0;
    logic [7:0]        pay [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte on the next edge; returns #1 after that edge so registered results are visible.
    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_err"}, frame_err, 0);
        check({tag, "_base"}, frame_base, 0);
        check({tag, "_len"}, frame_len, 0);
        check({tag, "_in_frame"}, in_frame, 0);
    endtask

    // Sends a complete frame built from pay[0..len-1]; model computes checksum, write addresses and outcome.
    task automatic send_frame(input logic [ADDR_W-1:0] addr, input int len, input int gap_max,
                              input bit bad, input int chk_ovr, input int stall_at);
        logic [7:0]        ahi, lenb, sum, chk;
        logic [ADDR_W-1:0] a;
        bit                good;
        int                g;
        ahi  = {5'($urandom), addr[10:8]};
        lenb = 8'(len);
        sum  = ahi + addr[7:0] + lenb;
        for (int i = 0; i < len; i++) sum = sum + pay[i];
        chk = 8'(0) - sum;
        if (bad) chk = chk + 8'($urandom_range(1, 255));
        if (chk_ovr >= 0) chk = 8'(chk_ovr);
        good = (8'(sum + chk) == 8'h00);

        send_byte(8'h55);
        check("sync_in_frame", in_frame, 1);
        send_byte(ahi);
        send_byte(addr[7:0]);
        send_byte(lenb);
        check("hdr_no_write", wr_en, 0);
        for (int i = 0; i < len; i++) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            if (i == stall_at) g = TMO - 1;
            if (g > 0) begin
                idle(g);
                check("gap_wr_en", wr_en, 0);
                check("gap_err", frame_err, 0);
            end
            send_byte(pay[i]);
            a = addr + ADDR_W'(i);
            check("wr_en", wr_en, 1);
            check("wr_addr", wr_addr, a);
            check("wr_data", wr_data, pay[i]);
        end
        send_byte(chk);
        if (good) begin
            exp_base = addr;
            exp_len  = 9'(len);
        end
        check("frame_done", frame_done, good);
        check("frame_err", frame_err, !good);
        check("frame_base", frame_base, exp_base);
        check("frame_len", frame_len, exp_len);
        check("end_in_frame", in_frame, 0);
        check("chk_no_write", wr_en, 0);
`ifdef HOST_FRAME_ACK_EN
        ack_q.push_back(good ? 8'h06 : 8'h15);
`endif
        idle(1);
        check("done_pulse_width", frame_done, 0);
        check("err_pulse_width", frame_err, 0);
    endtask

`ifdef HOST_FRAME_ACK_EN
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_busy = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst_n && new_tx_data) begin
            check("ack_while_busy", tx_busy, 0);
            check("ack_expected", ack_q.size() != 0, 1);
            if (ack_q.size() != 0) check("ack_byte", tx_data, ack_q.pop_front());
        end
    end
`endif

    initial begin
        int n;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        send_byte(8'h00);
        check("junk_idle", in_frame, 0);
        send_byte(8'hFF);
        check("junk_idle2", in_frame, 0);
        check("junk_no_write", wr_en, 0);

        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
        send_frame(11'h100, 4, 2, 0, -1, -1);
        send_frame(11'h100, 4, 0, 0, 0, -1);

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(11'h7FE, 3, 1, 0, -1, -1);

        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        send_frame(11'($urandom), 256, 0, 0, -1, -1);

        for (int f = 0; f < 12; f++) begin
            int len;
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            if (f % 2 == 0) pay[0] = 8'h55;
            send_frame(11'($urandom), len, 3, ($urandom_range(0, 2) == 0), -1, (f == 3) ? 1 : -1);
        end

        // Stall after ADDR_LO and expect the timeout at exactly TMO idle cycles.
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h00);
        n = 0;
        seen = 0;
        while (n < TMO + 5 && !seen) begin
            idle(1);
            n++;
            if (frame_err) seen = 1;
            else check("tmo_in_frame", in_frame, 1);
        end
        check("tmo_fired", seen, 1);
        check("tmo_latency", n, TMO);
        check("tmo_idle", in_frame, 0);
        check("tmo_no_done", frame_done, 0);
        check("tmo_base_kept", frame_base, exp_base);
        check("tmo_len_kept", frame_len, exp_len);
`ifdef HOST_FRAME_ACK_EN
        ack_q.push_back(8'h15);
`endif
        idle(1);
        check("tmo_err_width", frame_err, 0);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("post_tmo_junk", in_frame, 0);
        pay[0] = 8'h5A; pay[1] = 8'hA5;
        send_frame(11'h2F0, 2, 1, 0, -1, -1);
        idle(20);

        // Asynchronous reset in the middle of DATA.
        send_byte(8'h55);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h0A);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i));
        check("pre_rst_wr_en", wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_done", frame_done, 0);
            check("rst_no_err", frame_err, 0);
        end
        rst_n = 1'b1;
        exp_base = '0;
        exp_len  = '0;
        idle(2);
        check("post_rst_idle", in_frame, 0);
        check("post_rst_err", frame_err, 0);
        pay[0] = 8'h01;
        send_frame(11'h000, 1, 0, 0, -1, -1);

        idle(20);
`ifdef HOST_FRAME_ACK_EN
        check("ack_drained", ack_q.size(), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
